y86_instr_encoder: RTL
======================

// Module: y86_instr_encoder
// PURPOSE
//  Encoder side of the Y86-64 instruction byte format that the fetch stage decodes. Accepts one
//  decoded instruction (icode, ifun, rA, rB, valC) per handshake and emits its bytes as a
//  byte-serial write stream, with addresses, into instruction memory. Used as the program loader
//  and self-check source for pipeline benches. Also flags illegal instructions and memory overflow.
// PARAMETERS
//  BASE_ADDR  64'd0     address of the first emitted byte after reset
//  MEM_BYTES  1024      instruction memory size in bytes; valid addresses are 0..MEM_BYTES-1
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  in_valid     in   1   decoded instruction present
//  in_ready     out  1   encoder can accept; transfer when in_valid && in_ready
//  in_icode     in   4   instruction code (IHALT..IPOPQ = 0..11)
//  in_ifun      in   4   function code
//  in_rA        in   4   register A (ignored unless the icode has a register byte)
//  in_rB        in   4   register B (ignored unless the icode has a register byte)
//  in_valC      in   64  constant (ignored unless the icode carries valC)
//  out_valid    out  1   out_byte/out_addr valid
//  out_ready    in   1   memory accepts; byte transfers when out_valid && out_ready
//  out_byte     out  8   encoded byte
//  out_addr     out  64  byte address of out_byte
//  out_last     out  1   out_byte is the final byte of the current instruction
//  stat         out  3   SAOK=1, SADR=2, SINS=3 (same codes as the fetch stage)
//  err_pulse    out  1   one-cycle pulse when an instruction is rejected
//  bytes_total  out  64  count of bytes transferred since reset
// BEHAVIOUR
//  Reset values: in_ready=1, out_valid=0, out_byte=0, out_addr=BASE_ADDR, out_last=0,
//  stat=SAOK, err_pulse=0, bytes_total=0, state=IDLE.
//  - Length: len = 1 + need_regids + 8*need_valC.
//      need_regids: RRMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, PUSHQ, POPQ.
//      need_valC:   IRMOVQ, RMMOVQ, MRMOVQ, JXX, CALL.
//  - Byte order:
//      byte0 = {icode, ifun};
//      byte1 = {rA, rB} if need_regids;
//      then valC little-endian (valC[7:0] first). No other bytes are emitted.
//  - Legality: an instruction is SINS if any of these holds:
//      icode > 11;
//      RRMOVQ or JXX with ifun > 6;
//      OPQ with ifun > 3;
//      any other icode with ifun != 0.
//  - Overflow: an instruction is SADR if out_addr + len > MEM_BYTES. Compute this in 65 bits;
//    no wrap-around.
//  - States:
//      IDLE: in_ready=1.
//        Accept a legal instruction -> EMIT. Latch the fields, byte_idx=0, first byte valid the
//        next cycle (latency 1).
//        Accept an illegal or overflowing instruction -> ERR. Set stat, err_pulse=1 for one
//        cycle, emit nothing.
//      EMIT: in_ready=0, out_valid=1.
//        On each out handshake: byte_idx++, out_addr++, bytes_total++.
//        out_last=1 when byte_idx == len-1.
//        Handshake on the last byte -> IDLE (one bubble cycle between instructions).
//      ERR: sticky. in_ready=0, out_valid=0, stat held. Only rst leaves ERR.
//  - While out_ready=0 in EMIT: out_byte, out_addr and out_last hold stable. Never drop
//    out_valid.
//  - rst mid-EMIT: remaining bytes are abandoned and all outputs return to reset values. Bytes
//    already written are not recalled.
//  - IHALT is encoded like any 1-byte instruction. Encoding does not stop after HALT.
//  - in_valid and in_ready are checked in the same cycle as EMIT completion; the next accept
//    occurs in IDLE only.
// STRUCTURE
//  - Shared package y86_pkg: icode constants (IHALT..IPOPQ), FNONE, RNONE=15, RESP=4, stat codes
//    SAOK/SADR/SINS/SHLT. The fetch stage uses the same package.
//  - Sub-module y86_instr_len: combinational icode/ifun -> {need_regids, need_valC, len[3:0],
//    legal}. The fetch stage can reuse it.
//  - Top: FSM (IDLE/EMIT/ERR), 4-bit byte_idx, 64-bit address and byte counters, byte mux.
// TESTING
//  1. irmovq $0x0123456789ABCDEF,%rbx (icode 3, rA=F, rB=3) at BASE 0, out_ready=1
//     -> bytes 30,F3,EF,CD,AB,89,67,45,23,01 at addr 0..9; out_last on addr 9; bytes_total=10.
//  2. nop, addq %rax,%rcx, ret back-to-back
//     -> 10 @0; 60 01 @1..2; 90 @3; one bubble between instructions; stat=SAOK.
//  3. call 0x40 with out_ready toggling 1-0-0-1 ...
//     -> bytes 80,40,00x7; out_byte/out_addr stable during stalls; 9 transfers total.
//  4. opq ifun=4, then icode=12
//     -> first: err_pulse, stat=SINS, ERR, no bytes emitted, in_ready=0 until rst.
//  5. MEM_BYTES=16, out_addr=10, jmp (len 9)
//     -> stat=SADR, no bytes emitted; halt at addr 15 accepted if issued first.
//  6. rst asserted after 3 of 10 bytes of irmovq
//     -> next cycle out_valid=0, out_addr=BASE_ADDR, bytes_total=0, in_ready=1.

Source files
------------

// File: rtl/y86_pkg.sv
// Y86-64 shared definitions for encoder and fetch: icodes, register ids, status codes.
// Pure declarations; no latency or flow control.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] FNONE = 4'h0;
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RESP  = 4'h4;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd2;
    localparam logic [2:0] SINS = 3'd3;
    localparam logic [2:0] SHLT = 3'd4;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_ERR
    } enc_state_t;

endpackage

// File: rtl/y86_instr_len.sv
// Instruction shape/legality from icode/ifun: regid byte, valC presence, byte length.
// Purely combinational, zero latency; no flow control.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    output logic       need_regids,
    output logic       need_valc,
    output logic [3:0] len,
    output logic       legal
);

    always_comb begin
        need_regids = icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
        need_valc   = icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
        len         = 4'd1 + {3'b000, need_regids} + (need_valc ? 4'd8 : 4'd0);

        legal = 1'b0;
        if (icode > IPOPQ)
            legal = 1'b0;
        else if (icode == IRRMOVQ || icode == IJXX)
            legal = (ifun <= 4'd6);
        else if (icode == IOPQ)
            legal = (ifun <= 4'd3);
        else
            legal = (ifun == FNONE);
    end

endmodule

// File: rtl/y86_instr_encoder.sv
// Y86-64 instruction -> byte-serial memory write stream; first byte 1 cycle after accept.
// Output holds stable under out_ready=0; in_ready drops while emitting and sticks low after an error.
module y86_instr_encoder
    import y86_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_icode,
    input  logic [3:0]  in_ifun,
    input  logic [3:0]  in_rA,
    input  logic [3:0]  in_rB,
    input  logic [63:0] in_valC,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic [63:0] out_addr,
    output logic        out_last,
    output logic [2:0]  stat,
    output logic        err_pulse,
    output logic [63:0] bytes_total
);

    enc_state_t state, state_nxt;
    instr_t     cur;
    logic [3:0] byte_idx;
    logic [3:0] cur_len;
    logic       cur_regids;

    logic       in_need_regids;
    logic       in_need_valc;
    logic [3:0] in_len;
    logic       in_legal;

    logic       accept;
    logic       xfer;
    logic       overflow;
    logic [2:0] valc_idx;

    y86_instr_len u_len (
        .icode       (in_icode),
        .ifun        (in_ifun),
        .need_regids (in_need_regids),
        .need_valc   (in_need_valc),
        .len         (in_len),
        .legal       (in_legal)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_EMIT);
    assign out_last  = out_valid && (byte_idx == cur_len - 4'd1);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    // 65-bit compare so an address near 2^64 cannot wrap into range.
    assign overflow = ({1'b0, out_addr} + {61'd0, in_len}) > 65'(MEM_BYTES);

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nxt = (in_legal && !overflow) ? ST_EMIT : ST_ERR;
            end
            ST_EMIT: begin
                if (xfer && out_last)
                    state_nxt = ST_IDLE;
            end
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= '0;
            byte_idx    <= 4'd0;
            cur_len     <= 4'd0;
            cur_regids  <= 1'b0;
            out_addr    <= BASE_ADDR;
            bytes_total <= 64'd0;
            stat        <= SAOK;
            err_pulse   <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (state == ST_IDLE && accept) begin
                if (!in_legal) begin
                    stat      <= SINS;
                    err_pulse <= 1'b1;
                end else if (overflow) begin
                    stat      <= SADR;
                    err_pulse <= 1'b1;
                end else begin
                    // Unused fields are zeroed so they cannot leak into the byte mux.
                    cur.icode  <= in_icode;
                    cur.ifun   <= in_ifun;
                    cur.ra     <= in_need_regids ? in_rA : 4'd0;
                    cur.rb     <= in_need_regids ? in_rB : 4'd0;
                    cur.valc   <= in_need_valc ? in_valC : 64'd0;
                    cur_len    <= in_len;
                    cur_regids <= in_need_regids;
                    byte_idx   <= 4'd0;
                end
            end else if (xfer) begin
                byte_idx    <= byte_idx + 4'd1;
                out_addr    <= out_addr + 64'd1;
                bytes_total <= bytes_total + 64'd1;
            end
        end
    end

    assign valc_idx = 3'(byte_idx - 4'd1 - {3'b000, cur_regids});

    always_comb begin
        out_byte = 8'h00;
        if (out_valid) begin
            if (byte_idx == 4'd0)
                out_byte = {cur.icode, cur.ifun};
            else if (cur_regids && byte_idx == 4'd1)
                out_byte = {cur.ra, cur.rb};
            else
                out_byte = cur.valc[{valc_idx, 3'b000} +: 8];
        end
    end

endmodule
